// File: rtl/hazard_ctrl.sv
// Pipeline hazard sequencer: load-use stalls, branch flushes and MUL/DIV freeze with a watchdog.
// Optional macro HAZARD_PERF_EN adds the stall_cycles / flush_events performance counters.
module hazard_ctrl #(
    parameter int MD_MAX_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        MemRead_ex,
    input  logic [4:0]  rdAddr_ex,
    input  logic [4:0]  rs1Addr_id,
    input  logic [4:0]  rs2Addr_id,
    input  logic        rs1Used_id,
    input  logic        rs2Used_id,
    input  logic        BranchTaken_ex,
    input  logic        MulDiv_ex,
    input  logic        md_done,
    output logic        md_start,
    output logic        PC_IFWrite,
    output logic        IF_ID_Write,
    output logic        IF_ID_Flush,
    output logic        ID_EX_Write,
    output logic        ID_EX_Flush,
    output logic        EX_MEM_Bubble,
    output logic        md_timeout
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_events
`endif
);

    localparam int               CNT_W    = $clog2(MD_MAX_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MD_MAX_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_SAT  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [0:0] {
        ST_RUN     = 1'b0,
        ST_MD_BUSY = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] md_cnt_q, md_cnt_d;
    logic             md_timeout_q, md_timeout_d;

    logic lu;
    logic branch;
    logic md_launch;
    logic busy_hold;
    logic hold;

    // State, watchdog counter and sticky timeout flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_RUN;
            md_cnt_q     <= '0;
            md_timeout_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            md_cnt_q     <= md_cnt_d;
            md_timeout_q <= md_timeout_d;
        end
    end

    // Next-state logic for the MUL/DIV handshake
    always_comb begin
        state_d      = state_q;
        md_cnt_d     = md_cnt_q;
        md_timeout_d = md_timeout_q;
        md_launch    = 1'b0;
        busy_hold    = 1'b0;
        case (state_q)
            ST_RUN: begin
                // A branch in EX kills the MulDiv instruction, so no launch.
                if (MulDiv_ex && !BranchTaken_ex) begin
                    md_launch = 1'b1;
                    md_cnt_d  = '0;
                    state_d   = ST_MD_BUSY;
                end else begin
                    state_d   = ST_RUN;
                end
            end
            ST_MD_BUSY: begin
                if (md_done) begin
                    state_d = ST_RUN;
                end else if (md_cnt_q == CNT_LAST) begin
                    md_timeout_d = 1'b1;
                    state_d      = ST_RUN;
                end else begin
                    busy_hold = 1'b1;
                    if (md_cnt_q != CNT_SAT) begin
                        md_cnt_d = md_cnt_q + CNT_ONE;
                    end else begin
                        md_cnt_d = md_cnt_q;
                    end
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // Hazard classification and pipeline-register enables
    always_comb begin
        hold   = md_launch | busy_hold;
        branch = BranchTaken_ex;
        lu     = MemRead_ex && (rdAddr_ex != 5'd0) &&
                 ((rs1Used_id && (rdAddr_ex == rs1Addr_id)) ||
                  (rs2Used_id && (rdAddr_ex == rs2Addr_id)));

        md_start      = 1'b0;
        PC_IFWrite    = 1'b1;
        IF_ID_Write   = 1'b1;
        IF_ID_Flush   = 1'b0;
        ID_EX_Write   = 1'b1;
        ID_EX_Flush   = 1'b0;
        EX_MEM_Bubble = 1'b0;
        // Reset values are forced while rst_n is low, regardless of inputs.
        if (!rst_n) begin
            md_start = 1'b0;
        end else if (hold) begin
            md_start      = md_launch;
            PC_IFWrite    = 1'b0;
            IF_ID_Write   = 1'b0;
            ID_EX_Write   = 1'b0;
            EX_MEM_Bubble = 1'b1;
        end else if (branch) begin
            IF_ID_Flush = 1'b1;
            ID_EX_Flush = 1'b1;
        end else if (lu) begin
            PC_IFWrite  = 1'b0;
            IF_ID_Write = 1'b0;
            ID_EX_Flush = 1'b1;
        end else begin
            md_start = 1'b0;
        end
    end

    assign md_timeout = md_timeout_q;

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cycles_q, stall_cycles_d;
    logic [31:0] flush_events_q, flush_events_d;

    // Performance counter increments; a branch masks a coincident load-use
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        flush_events_d = flush_events_q;
        if (hold || (lu && !branch)) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
        end else begin
            stall_cycles_d = stall_cycles_q;
        end
        if (branch && !hold) begin
            flush_events_d = flush_events_q + 32'd1;
        end else begin
            flush_events_d = flush_events_q;
        end
    end

    // Performance counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles_q <= 32'd0;
            flush_events_q <= 32'd0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            flush_events_q <= flush_events_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_events = flush_events_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: per-cycle expected enables are queued with the stimulus
// and compared against the outputs at the following falling edge.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       MemRead_ex;
    logic [4:0] rdAddr_ex;
    logic [4:0] rs1Addr_id;
    logic [4:0] rs2Addr_id;
    logic       rs1Used_id;
    logic       rs2Used_id;
    logic       BranchTaken_ex;
    logic       MulDiv_ex;
    logic       md_done;
    logic       md_start;
    logic       PC_IFWrite;
    logic       IF_ID_Write;
    logic       IF_ID_Flush;
    logic       ID_EX_Write;
    logic       ID_EX_Flush;
    logic       EX_MEM_Bubble;
    logic       md_timeout;
`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cycles;
    logic [31:0] flush_events;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // {md_start, PC_IFWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Write, ID_EX_Flush, EX_MEM_Bubble, md_timeout}
    localparam logic [7:0] V_NORM   = 8'b0110_1000;
    localparam logic [7:0] V_LU     = 8'b0000_1100;
    localparam logic [7:0] V_BR     = 8'b0111_1100;
    localparam logic [7:0] V_START  = 8'b1000_0010;
    localparam logic [7:0] V_BUSY   = 8'b0000_0010;
    localparam logic [7:0] V_TO     = 8'b0000_0001;

    logic [7:0] exp_q[$];
    string      name_q[$];

    hazard_ctrl #(.MD_MAX_CYCLES(64)) dut (
        .clk(clk), .rst_n(rst_n),
        .MemRead_ex(MemRead_ex), .rdAddr_ex(rdAddr_ex),
        .rs1Addr_id(rs1Addr_id), .rs2Addr_id(rs2Addr_id),
        .rs1Used_id(rs1Used_id), .rs2Used_id(rs2Used_id),
        .BranchTaken_ex(BranchTaken_ex), .MulDiv_ex(MulDiv_ex), .md_done(md_done),
        .md_start(md_start), .PC_IFWrite(PC_IFWrite), .IF_ID_Write(IF_ID_Write),
        .IF_ID_Flush(IF_ID_Flush), .ID_EX_Write(ID_EX_Write), .ID_EX_Flush(ID_EX_Flush),
        .EX_MEM_Bubble(EX_MEM_Bubble), .md_timeout(md_timeout)
`ifdef HAZARD_PERF_EN
        , .stall_cycles(stall_cycles), .flush_events(flush_events)
`endif
    );

    always #5 clk = ~clk;

    task automatic drive(input logic mr, input logic [4:0] rd, input logic [4:0] r1,
                         input logic [4:0] r2, input logic u1, input logic u2,
                         input logic br, input logic md, input logic done);
        MemRead_ex = mr; rdAddr_ex = rd; rs1Addr_id = r1; rs2Addr_id = r2;
        rs1Used_id = u1; rs2Used_id = u2; BranchTaken_ex = br; MulDiv_ex = md; md_done = done;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Queue the expectation for the inputs just driven, compare at negedge, advance past posedge.
    task automatic step(input string nm, input logic [7:0] exp);
        logic [7:0] want;
        logic [7:0] got;
        string      cname;
        exp_q.push_back(exp);
        name_q.push_back(nm);
        @(negedge clk);
        want  = exp_q.pop_front();
        cname = name_q.pop_front();
        got   = {md_start, PC_IFWrite, IF_ID_Write, IF_ID_Flush,
                 ID_EX_Write, ID_EX_Flush, EX_MEM_Bubble, md_timeout};
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", cname, got, want);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        step("reset_outputs", V_NORM);
        idle();
        step("reset_still_low_idle", V_NORM);
        rst_n = 1'b1;
        step("after_release", V_NORM);
    endtask

    task automatic test_load_use();
        drive(1'b1, 5'd5, 5'd5, 5'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step("lu_rs1", V_LU);
        drive(1'b0, 5'd5, 5'd6, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step("lu_resolved", V_NORM);
        drive(1'b1, 5'd9, 5'd3, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step("lu_rs2", V_LU);
        drive(1'b1, 5'd9, 5'd3, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step("lu_rs2_unused", V_NORM);
        drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step("lu_rd_x0", V_NORM);
        drive(1'b1, 5'd7, 5'd7, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step("lu_no_src_used", V_NORM);
        drive(1'b0, 5'd7, 5'd7, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step("lu_not_load", V_NORM);
    endtask

    task automatic test_branch();
        drive(1'b1, 5'd5, 5'd5, 5'd1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        step("branch_over_lu", V_BR);
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        step("branch_with_muldiv", V_BR);
        idle();
        step("after_branch_muldiv", V_NORM);
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step("md_done_in_run", V_NORM);
    endtask

    task automatic test_muldiv(input logic [7:0] t);
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step("md_launch", V_START | t);
        for (int i = 1; i < 5; i++) begin
            // Branch/load-use inputs during the freeze must be masked.
            drive(1'b1, 5'd4, 5'd4, 5'd0, 1'b1, 1'b0, (i == 2), 1'b1, 1'b0);
            step($sformatf("md_busy_%0d", i), V_BUSY | t);
        end
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        step("md_done_release", V_NORM | t);
        idle();
        step("md_no_second_start", V_NORM | t);
    endtask

    task automatic test_back_to_back();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step("b2b_start1", V_START);
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        step("b2b_done1", V_NORM);
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step("b2b_start2", V_START);
        step("b2b_busy2", V_BUSY);
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        step("b2b_done2", V_NORM);
        idle();
        step("b2b_idle", V_NORM);
    endtask

    task automatic test_timeout();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step("to_launch", V_START);
        for (int i = 0; i < 63; i++) begin
            step($sformatf("to_held_%0d", i), V_BUSY);
        end
        idle();
        step("to_release", V_NORM);
        step("to_flag_set", V_NORM | V_TO);
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step("to_flag_sticky", V_NORM | V_TO);
        test_muldiv(V_TO);
    endtask

    task automatic test_reset_mid_busy();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step("rmb_launch", V_START | V_TO);
        step("rmb_busy", V_BUSY | V_TO);
        rst_n = 1'b0;
        step("rmb_in_reset", V_NORM);
        rst_n = 1'b1;
        idle();
        step("rmb_release1", V_NORM);
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step("rmb_stale_done", V_NORM);
        idle();
        step("rmb_release3", V_NORM);
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step("rmb_new_start", V_START);
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        step("rmb_new_done", V_NORM);
        idle();
        step("rmb_idle", V_NORM);
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        #1;
        test_reset();
        test_load_use();
        test_branch();
        test_muldiv(8'b0000_0000);
        test_back_to_back();
        test_timeout();
        test_reset_mid_busy();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
